// File: rtl/mips_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | mips_ctrl_pkg : shared opcodes, state encoding and datapath select codes    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC_R = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_EXEC_I = 4'd8;
    localparam logic [3:0] S_IWB    = 4'd9;
    localparam logic [3:0] S_BRANCH = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_JAL    = 4'd12;
    localparam logic [3:0] S_JR     = 4'd13;
    localparam logic [3:0] S_TRAP   = 4'd14;

    localparam logic [2:0] ALU_LUI   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_ADD   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_AND   = 3'b110;
    localparam logic [2:0] ALU_RTYPE = 3'b111;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] ALUB_REG     = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    function automatic logic op_known(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI,
            OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

    // Successor of DECODE; unknown opcodes trap or retire as a NOP.
    function automatic logic [3:0] decode_dispatch(input logic [5:0] op,
                                                   input logic [5:0] funct,
                                                   input logic       illegal_trap);
        case (op)
            OP_RTYPE:                         return (funct == FUNCT_JR) ? S_JR : S_EXEC_R;
            OP_J:                             return S_JUMP;
            OP_JAL:                           return S_JAL;
            OP_BEQ, OP_BNE:                   return S_BRANCH;
            OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: return S_EXEC_I;
            OP_LW, OP_SW:                     return S_MEMADR;
            default:                          return illegal_trap ? S_TRAP : S_FETCH;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_decode.sv
// +----------------------------------------------------------------------------+
// | multicycle_ctrl_decode : Moore output decode of state and latched opcode    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module multicycle_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond_eq,
    output logic       pc_write_cond_ne,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] mem_to_reg,
    output logic [1:0] reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source
);

    always_comb begin
        pc_write         = 1'b0;
        pc_write_cond_eq = 1'b0;
        pc_write_cond_ne = 1'b0;
        i_or_d           = 1'b0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        ir_write         = 1'b0;
        mem_to_reg       = M2R_ALUOUT;
        reg_dst          = REGDST_RT;
        reg_write        = 1'b0;
        alu_src_a        = 1'b0;
        alu_src_b        = ALUB_REG;
        alu_op           = ALU_LUI;
        pc_source        = PCSRC_ALU;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALUB_FOUR;
                alu_op    = ALU_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = ALUB_IMM_SH2;
                alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MDR;
                reg_dst    = REGDST_RT;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_RTYPE;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = REGDST_RD;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                case (op)
                    OP_ANDI: alu_op = ALU_AND;
                    OP_ORI:  alu_op = ALU_OR;
                    OP_LUI:  alu_op = ALU_LUI;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_IWB: begin
                reg_write = 1'b1;
                reg_dst   = REGDST_RT;
            end
            S_BRANCH: begin
                alu_src_a        = 1'b1;
                alu_op           = ALU_SUB;
                pc_source        = PCSRC_ALUOUT;
                pc_write_cond_eq = (op == OP_BEQ);
                pc_write_cond_ne = (op == OP_BNE);
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                reg_write  = 1'b1;
                reg_dst    = REGDST_RA;
                mem_to_reg = M2R_PC;
            end
            S_JR: begin
                // JR is only reachable with funct = JR; the guard keeps the
                // latched instruction fields self-consistent.
                pc_write  = (funct == FUNCT_JR);
                pc_source = PCSRC_RS;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// +----------------------------------------------------------------------------+
// | multicycle_control : multicycle MIPS control FSM with retire counter       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter logic ILLEGAL_TRAP = 1'b1,
    parameter int   CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond_eq,
    output logic             pc_write_cond_ne,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic [1:0]       mem_to_reg,
    output logic [1:0]       reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state_dbg
);

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [5:0]       r_op;
    logic [5:0]       r_funct;
    logic [CNT_W-1:0] r_count;
    logic             r_done;
    logic             r_illegal;
    logic             w_retire;
    logic             w_unknown_dec;

    logic       w_pc_write, w_cond_eq, w_cond_ne, w_i_or_d, w_mem_read, w_mem_write;
    logic       w_ir_write, w_reg_write, w_alu_src_a;
    logic [1:0] w_mem_to_reg, w_reg_dst, w_alu_src_b, w_pc_source;
    logic [2:0] w_alu_op;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (mem_ready) w_next = S_DECODE;
            S_DECODE: w_next = decode_dispatch(op, funct, ILLEGAL_TRAP);
            S_MEMADR: w_next = (r_op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWR:  if (mem_ready) w_next = S_FETCH;
            S_EXEC_R: w_next = S_RWB;
            S_EXEC_I: w_next = S_IWB;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_FETCH;
        endcase
    end

    assign w_retire      = (w_next == S_FETCH) && (r_state != S_FETCH);
    assign w_unknown_dec = (r_state == S_DECODE) && !op_known(op);

    // instr_done is registered, so it lines up with the updated count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_op      <= '0;
            r_funct   <= '0;
            r_count   <= '0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_retire;
            if (w_retire)
                r_count <= r_count + CNT_W'(1);
            if (r_state == S_DECODE) begin
                r_op    <= op;
                r_funct <= funct;
            end
            if (ILLEGAL_TRAP && (r_state == S_DECODE) && (w_next == S_TRAP))
                r_illegal <= 1'b1;
        end
    end

    multicycle_ctrl_decode u_decode (
        .state            (r_state),
        .op               (r_op),
        .funct            (r_funct),
        .mem_ready        (mem_ready),
        .pc_write         (w_pc_write),
        .pc_write_cond_eq (w_cond_eq),
        .pc_write_cond_ne (w_cond_ne),
        .i_or_d           (w_i_or_d),
        .mem_read         (w_mem_read),
        .mem_write        (w_mem_write),
        .ir_write         (w_ir_write),
        .mem_to_reg       (w_mem_to_reg),
        .reg_dst          (w_reg_dst),
        .reg_write        (w_reg_write),
        .alu_src_a        (w_alu_src_a),
        .alu_src_b        (w_alu_src_b),
        .alu_op           (w_alu_op),
        .pc_source        (w_pc_source)
    );

    assign pc_write         = w_pc_write  & ~reset;
    assign pc_write_cond_eq = w_cond_eq   & ~reset;
    assign pc_write_cond_ne = w_cond_ne   & ~reset;
    assign i_or_d           = w_i_or_d    & ~reset;
    assign mem_read         = w_mem_read  & ~reset;
    assign mem_write        = w_mem_write & ~reset;
    assign ir_write         = w_ir_write  & ~reset;
    assign reg_write        = w_reg_write & ~reset;
    assign alu_src_a        = w_alu_src_a & ~reset;
    assign mem_to_reg       = reset ? 2'b00 : w_mem_to_reg;
    assign reg_dst          = reset ? 2'b00 : w_reg_dst;
    assign alu_src_b        = reset ? 2'b00 : w_alu_src_b;
    assign alu_op           = reset ? 3'b000 : w_alu_op;
    assign pc_source        = reset ? 2'b00 : w_pc_source;
    assign illegal_op       = ~reset & (ILLEGAL_TRAP ? r_illegal : w_unknown_dec);
    assign instr_done       = r_done & ~reset;
    assign instr_count      = reset ? '0 : r_count;
    assign state_dbg        = reset ? 4'd0 : r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// +----------------------------------------------------------------------------+
// | tb_multicycle_control : scoreboard bench, trap and NOP variants            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    typedef struct packed {
        logic [3:0]  st;
        logic [19:0] ctrl;
        logic        ill;
        logic        done;
        logic [31:0] cnt;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [2];
    logic [5:0] opi [2];
    logic [5:0] fni [2];
    logic       rdy [2];

    logic       pcw [2], ceq [2], cne [2], iord [2], mrd [2], mwr [2], irw [2];
    logic [1:0] m2r [2], rdst [2], asb [2], pcs [2];
    logic       rgw [2], asa [2], ill [2], done [2];
    logic [2:0] aop [2];
    logic [3:0] sdbg [2];
    logic [2:0] cnt0;
    logic [31:0] cnt1;

    multicycle_control #(.ILLEGAL_TRAP(1'b1), .CNT_W(3)) dut (
        .clk(clk), .reset(rst[0]), .op(opi[0]), .funct(fni[0]), .mem_ready(rdy[0]),
        .pc_write(pcw[0]), .pc_write_cond_eq(ceq[0]), .pc_write_cond_ne(cne[0]),
        .i_or_d(iord[0]), .mem_read(mrd[0]), .mem_write(mwr[0]), .ir_write(irw[0]),
        .mem_to_reg(m2r[0]), .reg_dst(rdst[0]), .reg_write(rgw[0]), .alu_src_a(asa[0]),
        .alu_src_b(asb[0]), .alu_op(aop[0]), .pc_source(pcs[0]), .illegal_op(ill[0]),
        .instr_done(done[0]), .instr_count(cnt0), .state_dbg(sdbg[0])
    );

    multicycle_control #(.ILLEGAL_TRAP(1'b0), .CNT_W(32)) dut_nop (
        .clk(clk), .reset(rst[1]), .op(opi[1]), .funct(fni[1]), .mem_ready(rdy[1]),
        .pc_write(pcw[1]), .pc_write_cond_eq(ceq[1]), .pc_write_cond_ne(cne[1]),
        .i_or_d(iord[1]), .mem_read(mrd[1]), .mem_write(mwr[1]), .ir_write(irw[1]),
        .mem_to_reg(m2r[1]), .reg_dst(rdst[1]), .reg_write(rgw[1]), .alu_src_a(asa[1]),
        .alu_src_b(asb[1]), .alu_op(aop[1]), .pc_source(pcs[1]), .illegal_op(ill[1]),
        .instr_done(done[1]), .instr_count(cnt1), .state_dbg(sdbg[1])
    );

    rec_t act [2];
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            act[d].st   = sdbg[d];
            act[d].ctrl = {pcw[d], ceq[d], cne[d], iord[d], mrd[d], mwr[d], irw[d],
                           m2r[d], rdst[d], rgw[d], asa[d], asb[d], aop[d], pcs[d]};
            act[d].ill  = ill[d];
            act[d].done = done[d];
            act[d].cnt  = 32'd0;
        end
        act[0].cnt = {29'd0, cnt0};
        act[1].cnt = cnt1;
    end

    rec_t q0 [$];
    rec_t q1 [$];
    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_cnt  [2];
    logic        exp_done [2];

    function automatic logic [19:0] cw(input logic p, e, n, io, mr, mw, ir,
                                       input logic [1:0] mt, rd, input logic rw, sa,
                                       input logic [1:0] sb, input logic [2:0] ao,
                                       input logic [1:0] ps);
        return {p, e, n, io, mr, mw, ir, mt, rd, rw, sa, sb, ao, ps};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(1, 0));
    endfunction

    function automatic logic known(input logic [5:0] o);
        return (o == 6'h00) || (o == 6'h02) || (o == 6'h03) || (o == 6'h04) ||
               (o == 6'h05) || (o == 6'h08) || (o == 6'h0c) || (o == 6'h0d) ||
               (o == 6'h0f) || (o == 6'h23) || (o == 6'h2b);
    endfunction

    // Monitor: one comparison per cycle for which an expectation is queued.
    initial begin
        rec_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if ((d == 0 && q0.size() > 0) || (d == 1 && q1.size() > 0)) begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    checks++;
                    if (act[d] !== e) begin
                        failures++;
                        $display("FAIL dut%0d cycle t=%0t: got st=%0d ctrl=%05h ill=%0b done=%0b cnt=%0d, expected st=%0d ctrl=%05h ill=%0b done=%0b cnt=%0d",
                                 d, $time, act[d].st, act[d].ctrl, act[d].ill, act[d].done, act[d].cnt,
                                 e.st, e.ctrl, e.ill, e.done, e.cnt);
                    end
                end
            end
        end
    end

    task automatic cyc(input int d, input logic r, input logic [5:0] o, f, input logic m,
                       input logic [3:0] st, input logic [19:0] c, input logic il);
        rec_t e;
        e.st = st; e.ctrl = c; e.ill = il; e.cnt = exp_cnt[d];
        e.done = (st == S_FETCH) && exp_done[d];
        if (st == S_FETCH) exp_done[d] = 1'b0;
        if (r) begin
            e = '0;
            exp_cnt[d]  = 32'd0;
            exp_done[d] = 1'b0;
        end
        rst[d] = r; opi[d] = o; fni[d] = f; rdy[d] = m;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int d, input logic [3:0] st, input logic [19:0] c, input logic m);
        cyc(d, 1'b0, 6'($urandom), 6'($urandom), m, st, c, 1'b0);
    endtask

    task automatic reset_cyc(input int d);
        cyc(d, 1'b1, 6'($urandom), 6'($urandom), rb(), S_FETCH, 20'd0, 1'b0);
    endtask

    task automatic retire(input int d);
        exp_done[d] = 1'b1;
        exp_cnt[d]  = (d == 0) ? ((exp_cnt[d] + 32'd1) & 32'h7) : (exp_cnt[d] + 32'd1);
    endtask

    task automatic fetch_decode(input int d, input logic [5:0] o, f, input int fw);
        for (int i = 0; i < fw; i++)
            step(d, S_FETCH, cw(0,0,0,0,1,0,0,2'b00,2'b00,0,0,2'b01,3'b100,2'b00), 1'b0);
        step(d, S_FETCH, cw(1,0,0,0,1,0,1,2'b00,2'b00,0,0,2'b01,3'b100,2'b00), 1'b1);
        cyc(d, 1'b0, o, f, rb(), S_DECODE,
            cw(0,0,0,0,0,0,0,2'b00,2'b00,0,0,2'b11,3'b100,2'b00), (d == 1) && !known(o));
    endtask

    task automatic instr(input int d, input logic [5:0] o, f, input int fw, mw);
        fetch_decode(d, o, f, fw);
        case (o)
            6'h00: begin
                if (f == 6'h08) begin
                    step(d, S_JR, cw(1,0,0,0,0,0,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b11), rb());
                end else begin
                    step(d, S_EXEC_R, cw(0,0,0,0,0,0,0,2'b00,2'b00,0,1,2'b00,3'b111,2'b00), rb());
                    step(d, S_RWB,    cw(0,0,0,0,0,0,0,2'b00,2'b01,1,0,2'b00,3'b000,2'b00), rb());
                end
            end
            6'h02: step(d, S_JUMP, cw(1,0,0,0,0,0,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b10), rb());
            6'h03: step(d, S_JAL,  cw(1,0,0,0,0,0,0,2'b10,2'b10,1,0,2'b00,3'b000,2'b10), rb());
            6'h04: step(d, S_BRANCH, cw(0,1,0,0,0,0,0,2'b00,2'b00,0,1,2'b00,3'b001,2'b01), rb());
            6'h05: step(d, S_BRANCH, cw(0,0,1,0,0,0,0,2'b00,2'b00,0,1,2'b00,3'b001,2'b01), rb());
            6'h08, 6'h0c, 6'h0d, 6'h0f: begin
                logic [2:0] a;
                a = (o == 6'h08) ? 3'b100 : (o == 6'h0c) ? 3'b110 : (o == 6'h0d) ? 3'b101 : 3'b000;
                step(d, S_EXEC_I, cw(0,0,0,0,0,0,0,2'b00,2'b00,0,1,2'b10,a,2'b00), rb());
                step(d, S_IWB,    cw(0,0,0,0,0,0,0,2'b00,2'b00,1,0,2'b00,3'b000,2'b00), rb());
            end
            6'h23: begin
                step(d, S_MEMADR, cw(0,0,0,0,0,0,0,2'b00,2'b00,0,1,2'b10,3'b100,2'b00), rb());
                for (int i = 0; i < mw; i++)
                    step(d, S_MEMRD, cw(0,0,0,1,1,0,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b00), 1'b0);
                step(d, S_MEMRD, cw(0,0,0,1,1,0,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b00), 1'b1);
                step(d, S_MEMWB, cw(0,0,0,0,0,0,0,2'b01,2'b00,1,0,2'b00,3'b000,2'b00), rb());
            end
            6'h2b: begin
                step(d, S_MEMADR, cw(0,0,0,0,0,0,0,2'b00,2'b00,0,1,2'b10,3'b100,2'b00), rb());
                for (int i = 0; i < mw; i++)
                    step(d, S_MEMWR, cw(0,0,0,1,0,1,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b00), 1'b0);
                step(d, S_MEMWR, cw(0,0,0,1,0,1,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b00), 1'b1);
            end
            default: ;
        endcase
        retire(d);
    endtask

    initial begin
        rst[0] = 1'b1; rst[1] = 1'b1;
        opi[0] = '0; opi[1] = '0; fni[0] = '0; fni[1] = '0; rdy[0] = 1'b0; rdy[1] = 1'b0;
        exp_cnt[0] = '0; exp_cnt[1] = '0; exp_done[0] = 1'b0; exp_done[1] = 1'b0;
        @(posedge clk);
        #1;

        reset_cyc(0);
        reset_cyc(0);
        instr(0, 6'h23, 6'h00, 0, 0);    // lw, zero wait
        instr(0, 6'h2b, 6'h11, 0, 3);    // sw, three wait states
        instr(0, 6'h04, 6'h08, 0, 0);    // beq
        instr(0, 6'h05, 6'h00, 0, 0);    // bne
        instr(0, 6'h03, 6'h08, 0, 0);    // jal
        instr(0, 6'h00, 6'h08, 0, 0);    // jr
        instr(0, 6'h00, 6'h20, 2, 0);    // add with fetch waits, count reaches 7
        instr(0, 6'h0d, 6'h08, 0, 0);    // ori, count wraps to 0
        instr(0, 6'h0c, 6'h00, 0, 0);
        instr(0, 6'h0f, 6'h00, 0, 0);
        instr(0, 6'h08, 6'h00, 0, 0);

        // Reset during a MEMRD wait state abandons the load.
        fetch_decode(0, 6'h23, 6'h00, 0);
        step(0, S_MEMADR, cw(0,0,0,0,0,0,0,2'b00,2'b00,0,1,2'b10,3'b100,2'b00), rb());
        step(0, S_MEMRD, cw(0,0,0,1,1,0,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b00), 1'b0);
        step(0, S_MEMRD, cw(0,0,0,1,1,0,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b00), 1'b0);
        reset_cyc(0);

        // Seven jumps bring the count to 7; reset then lands on the retire pulse.
        for (int i = 0; i < 7; i++) instr(0, 6'h02, 6'h00, 0, 0);
        reset_cyc(0);

        // Unknown opcode traps; illegal_op sticks and the count freezes.
        fetch_decode(0, 6'h3f, 6'h00, 1);
        for (int i = 0; i < 4; i++)
            cyc(0, 1'b0, 6'($urandom), 6'($urandom), rb(), S_TRAP, 20'd0, 1'b1);
        reset_cyc(0);
        step(0, S_FETCH, cw(0,0,0,0,1,0,0,2'b00,2'b00,0,0,2'b01,3'b100,2'b00), 1'b0);
        rst[0] = 1'b1;

        // NOP variant: unknown opcode pulses illegal_op and retires.
        reset_cyc(1);
        instr(1, 6'h3f, 6'h2a, 0, 0);
        instr(1, 6'h02, 6'h00, 0, 0);
        step(1, S_FETCH, cw(0,0,0,0,1,0,0,2'b00,2'b00,0,0,2'b01,3'b100,2'b00), 1'b0);
        step(1, S_FETCH, cw(0,0,0,0,1,0,0,2'b00,2'b00,0,0,2'b01,3'b100,2'b00), 1'b0);
        rst[1] = 1'b1;

        for (int i = 0; i < 20 && (q0.size() > 0 || q1.size() > 0); i++) @(posedge clk);
        if (q0.size() > 0 || q1.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d queued expectations, expected 0", q0.size() + q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Multicycle control unit for the MIPS core, succeeding the single-cycle opcode decoder. A Moore FSM sequences each instruction through fetch, decode, execute, memory and write-back steps, sharing one ALU and one memory port. Memory accesses use a ready handshake, so wait states are supported. An unknown opcode either traps or retires as a NOP, selected by a parameter. The block drives every datapath mux and enable in the multicycle core and keeps a retired-instruction counter.

## Interface
- ILLEGAL_TRAP, 1: 1 = unknown opcode enters TRAP (sticky); 0 = unknown opcode retires as NOP.
- CNT_W, 32: width of the retired-instruction counter.
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- op  in  6  IR[31:26]; sampled in DECODE.
- funct  in  6  IR[5:0]; sampled in DECODE.
- mem_ready  in  1  memory has completed the current access; sampled only in FETCH, MEMRD and MEMWR.
- pc_write, pc_write_cond_eq, pc_write_cond_ne  out  1 each  PC enables; the cond enables are ANDed with ALU zero / !zero in the datapath.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read, mem_write, ir_write  out  1 each  memory and IR strobes.
- mem_to_reg  out  2  write-back data select: 00 = ALUOut, 01 = MDR, 10 = PC.
- reg_dst  out  2  destination register select: 00 = rt, 01 = rd, 10 = $31.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A register.
- alu_src_b  out  2  ALU B select: 00 = B register, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_op  out  3  000 = LUI, 001 = SUB, 100 = ADD, 101 = OR, 110 = AND, 111 = R-type (decode funct).
- pc_source  out  2  PC source select: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = rs.
- illegal_op  out  1  unknown-opcode indication (see Operation).
- instr_done  out  1  one-cycle pulse when an instruction retires.
- instr_count  out  CNT_W  number of retired instructions.
- state_dbg  out  4  current state encoding.

## Operation
- States, with their outputs and transitions. Any output not listed is 0.
  - FETCH (0): mem_read = 1, alu_src_b = 01, alu_op = ADD. ir_write and pc_write equal mem_ready. Stays in FETCH while !mem_ready; goes to DECODE on mem_ready.
  - DECODE (1): alu_src_b = 11, alu_op = ADD (precomputes the branch target). Next state by op:
    - 0x00 with funct = 0x08 goes to JR; any other 0x00 goes to EXEC_R.
    - 0x02 goes to JUMP; 0x03 goes to JAL.
    - 0x04 and 0x05 go to BRANCH.
    - 0x08, 0x0c, 0x0d and 0x0f go to EXEC_I.
    - 0x23 and 0x2b go to MEMADR.
    - Any other op goes to TRAP if ILLEGAL_TRAP = 1, otherwise to FETCH.
  - MEMADR (2): alu_src_a = 1, alu_src_b = 10, alu_op = ADD. Goes to MEMRD for lw, MEMWR for sw.
  - MEMRD (3): mem_read = 1, i_or_d = 1. Waits for mem_ready, then goes to MEMWB.
  - MEMWB (4): reg_write = 1, mem_to_reg = 01, reg_dst = 00. Goes to FETCH.
  - MEMWR (5): mem_write = 1, i_or_d = 1. Waits for mem_ready, then goes to FETCH.
  - EXEC_R (6): alu_src_a = 1, alu_op = 111. Goes to RWB.
  - RWB (7): reg_write = 1, reg_dst = 01. Goes to FETCH.
  - EXEC_I (8): alu_src_a = 1, alu_src_b = 10. alu_op is ADD, AND, OR or LUI for op 08, 0c, 0d or 0f respectively. Goes to IWB.
  - IWB (9): reg_write = 1, reg_dst = 00. Goes to FETCH.
  - BRANCH (10): alu_src_a = 1, alu_op = SUB, pc_source = 01. Asserts pc_write_cond_eq for beq or pc_write_cond_ne for bne. Goes to FETCH.
  - JUMP (11): pc_write = 1, pc_source = 10. Goes to FETCH.
  - JAL (12): pc_write = 1, pc_source = 10, reg_write = 1, reg_dst = 10, mem_to_reg = 10. Goes to FETCH.
  - JR (13): pc_write = 1, pc_source = 11. Goes to FETCH.
  - TRAP (14): all strobes 0. Left only by reset.
- op and funct are latched into internal registers in DECODE. Later states use only the latched copies.
- instr_done = 1 on any transition into FETCH from a state other than FETCH. Each pulse increments instr_count by 1. instr_count wraps modulo 2^CNT_W.
- illegal_op:
  - ILLEGAL_TRAP = 1: set on the DECODE → TRAP transition, held until reset.
  - ILLEGAL_TRAP = 0: a one-cycle pulse during the DECODE of the unknown opcode. That NOP also pulses instr_done.

## Timing
- Outputs are a Moore decode of the state register. While reset = 1, all outputs are forced to 0.
- Reset values: state = FETCH, instr_count = 0, illegal_op = 0, latched op/funct = 0.
- Cycle counts with zero-wait memory (mem_ready = 1 on first sample):
  - j, jal, jr, beq, bne: 3 cycles.
  - R-type, I-type, sw: 4 cycles.
  - lw: 5 cycles.
- Each cycle mem_ready is low adds one cycle in FETCH, MEMRD or MEMWR. mem_read/mem_write stay asserted throughout the wait.
- mem_ready is ignored in every other state.
- Reset asserted mid-wait abandons the access: strobes drop in that same cycle and the FSM restarts in FETCH.
- Reset and instr_done in the same cycle: reset wins and instr_count becomes 0.

## Structure
- Shared package mips_ctrl_pkg holds:
  - opcode constants and the JR funct constant;
  - the state encoding;
  - ALUOp, pc_source, reg_dst, mem_to_reg and alu_src_b codes.
- Sub-module multicycle_ctrl_decode: pure combinational state + latched op → output vector.
- The top level holds the state register, the next-state logic, the op/funct latches and the counter.

## Test plan
- lw with mem_ready held at 1: states 0→1→2→3→4→0. MEMWB has reg_write = 1 and mem_to_reg = 01. One instr_done pulse; instr_count = 1.
- sw with mem_ready low for 3 cycles in MEMWR: mem_write and i_or_d stay high for 4 cycles, then return to FETCH. Total 7 cycles.
- beq then bne: BRANCH drives alu_op = 001 and pc_source = 01. pc_write_cond_eq only for op 0x04; pc_write_cond_ne only for op 0x05.
- jal then jr (funct 0x08):
  - jal: JAL with reg_dst = 10, mem_to_reg = 10, pc_source = 10.
  - jr: JR with pc_source = 11, reg_write = 0.
- op = 0x3f:
  - ILLEGAL_TRAP = 1: TRAP, illegal_op stays high, instr_count frozen.
  - ILLEGAL_TRAP = 0: one-cycle illegal_op pulse, back to FETCH, instr_count + 1.
- Reset asserted in MEMRD wait and at instr_count = 2^CNT_W − 1:
  - reset: all outputs 0 in the reset cycle, FETCH next, count = 0;
  - without reset, the next retire wraps instr_count to 0.
